// File: rtl/tau_gemm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tau_gemm_pkg                                               |
// | Description : Shared types and sizing helpers for the tau_gemm_tile      |
// |               temporal-MAC matrix-multiply tile.                         |
// |   state_t    - tile FSM state encoding (IDLE, LOAD, COMPUTE, DONE)       |
// |   acc_bits   - accumulator width for a given operand width and depth    |
// |   kcnt_bits  - width of the k-step counter / latched inner length       |
// |   bcnt_bits  - width of the bit-serial position counter                 |
// | Options     : TAU_GEMM_SIGNED_EN (used by the tile, not by this package) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tau_gemm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Each product fits in 2*width bits; summing k_max of them needs
  // log2(k_max) extra bits.
  function automatic int acc_bits(input int width, input int k_max);
    return 2 * width + $clog2(k_max);
  endfunction

  // Must hold the value k_max itself, hence the +1.
  function automatic int kcnt_bits(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  // Counts 0..width-1; kept at least one bit wide for width=1.
  function automatic int bcnt_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int c_KCNT_W_DEF = kcnt_bits(16);
  localparam int c_BCNT_W_DEF = bcnt_bits(8);

endpackage
`default_nettype wire

// File: rtl/tau_gemm_tile_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tau_mac_cell                                               |
// | Description : One bit-serial multiply-accumulate cell. On each enabled   |
// |               cycle it adds the operand A shifted by the current bit     |
// |               position when the selected bit of B is set.                |
// | Ports       : clk, reset_n   clock, async active-low reset               |
// |               i_clr          synchronous accumulator clear (priority)    |
// |               i_en           accumulate this cycle                       |
// |               i_a            A operand (WIDTH bits)                      |
// |               i_b_bit        B bit at position i_bit_idx                 |
// |               i_bit_idx      bit position, LSB first                     |
// |               o_acc          accumulator (ACC_BITS bits)                 |
// | Options     : TAU_GEMM_SIGNED_EN - A sign-extended, MSB term subtracted  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tau_mac_cell #(
  parameter int WIDTH    = 8,
  parameter int ACC_BITS = 20,
  parameter int BCNT_W   = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [WIDTH-1:0]    i_a,
  input  logic                i_b_bit,
  input  logic [BCNT_W-1:0]   i_bit_idx,
  output logic [ACC_BITS-1:0] o_acc
);

  logic [ACC_BITS-1:0] r_acc;
  logic [ACC_BITS-1:0] w_a_ext;
  logic [ACC_BITS-1:0] w_term;
  logic [ACC_BITS-1:0] w_next;
  logic                w_sub;

`ifdef TAU_GEMM_SIGNED_EN
  // Two's complement B: the MSB carries weight -2^(WIDTH-1), so its
  // partial product is subtracted rather than added.
  assign w_a_ext = {{(ACC_BITS-WIDTH){i_a[WIDTH-1]}}, i_a};
  assign w_sub   = (i_bit_idx == BCNT_W'(WIDTH-1));
`else
  assign w_a_ext = {{(ACC_BITS-WIDTH){1'b0}}, i_a};
  assign w_sub   = 1'b0;
`endif

  assign w_term = w_a_ext << i_bit_idx;

  always_comb begin
    w_next = r_acc;
    if (i_b_bit) begin
      w_next = w_sub ? (r_acc - w_term) : (r_acc + w_term);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/tau_gemm_tile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tau_gemm_tile                                              |
// | Description : ROWS x COLS temporal-MAC tile computing C = A*B over a     |
// |               run-time inner dimension. One A column and one B row are   |
// |               accepted per k-step and consumed bit-serially over WIDTH   |
// |               cycles by an array of tau_mac_cell instances.              |
// | Ports       : clk, reset_n     clock, async active-low reset             |
// |               i_start, i_k_len begin tile / inner length (IDLE only)     |
// |               o_busy           high outside IDLE                         |
// |               i_in_valid, o_in_ready   operand handshake (LOAD only)     |
// |               i_a_col          A[:,k], element i at [i*WIDTH +: WIDTH]   |
// |               i_b_row          B[k,:], element j at [j*WIDTH +: WIDTH]   |
// |               o_out_valid, i_out_ready result handshake (DONE)           |
// |               o_out            C, element (i,j) at                       |
// |                                [(i*COLS+j)*ACC_BITS +: ACC_BITS]         |
// | Options     : TAU_GEMM_SIGNED_EN - two's complement operands and result  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tau_gemm_tile
  import tau_gemm_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int WIDTH    = 8,
  parameter int K_MAX    = 16,
  parameter int ACC_BITS = acc_bits(WIDTH, K_MAX)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic [$clog2(K_MAX+1)-1:0]    i_k_len,
  output logic                          o_busy,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [ROWS*WIDTH-1:0]         i_a_col,
  input  logic [COLS*WIDTH-1:0]         i_b_row,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [ROWS*COLS*ACC_BITS-1:0] o_out
);

  localparam int                  c_KCNT_W = kcnt_bits(K_MAX);
  localparam int                  c_BCNT_W = bcnt_bits(WIDTH);
  localparam logic [c_KCNT_W-1:0] c_K_MAX  = c_KCNT_W'(K_MAX);
  localparam logic [c_BCNT_W-1:0] c_B_LAST = c_BCNT_W'(WIDTH-1);

  state_t                r_state;
  logic [c_KCNT_W-1:0]   r_k_len;
  logic [c_KCNT_W-1:0]   r_k_cnt;
  logic [c_BCNT_W-1:0]   r_bit_cnt;
  logic [ROWS*WIDTH-1:0] r_a;
  logic [COLS*WIDTH-1:0] r_b;

  logic w_clr;
  logic w_en;
  logic w_last;

  // Accumulators clear on the same edge that leaves IDLE, so both the LOAD
  // path and the k_len=0 path present a zeroed tile.
  assign w_clr  = (r_state == ST_IDLE) && i_start;
  assign w_en   = (r_state == ST_COMPUTE);
  assign w_last = (r_bit_cnt == c_B_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_k_len   <= '0;
      r_k_cnt   <= '0;
      r_bit_cnt <= '0;
      r_a       <= '0;
      r_b       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_k_cnt <= '0;
            if (i_k_len == '0) begin
              r_state <= ST_DONE;
            end else begin
              // Over-long requests are clamped rather than rejected.
              r_k_len <= (i_k_len > c_K_MAX) ? c_K_MAX : i_k_len;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (i_in_valid) begin
            r_a       <= i_a_col;
            r_b       <= i_b_row;
            r_bit_cnt <= '0;
            r_state   <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
          if (w_last) begin
            r_bit_cnt <= '0;
            r_k_cnt   <= r_k_cnt + c_KCNT_W'(1);
            if ((r_k_cnt + c_KCNT_W'(1)) == r_k_len) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs decode the state register directly; no input reaches
  // an output combinationally.
  assign o_busy      = (r_state != ST_IDLE);
  assign o_in_ready  = (r_state == ST_LOAD);
  assign o_out_valid = (r_state == ST_DONE);

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic [WIDTH-1:0] w_b_elem;
      assign w_b_elem = r_b[gj*WIDTH +: WIDTH];

      tau_mac_cell #(
        .WIDTH    (WIDTH),
        .ACC_BITS (ACC_BITS),
        .BCNT_W   (c_BCNT_W)
      ) u_cell (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (w_clr),
        .i_en      (w_en),
        .i_a       (r_a[gi*WIDTH +: WIDTH]),
        .i_b_bit   (w_b_elem[r_bit_cnt]),
        .i_bit_idx (r_bit_cnt),
        .o_acc     (o_out[(gi*COLS+gj)*ACC_BITS +: ACC_BITS])
      );
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tau_gemm_tile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tau_gemm_tile                                           |
// | Description : Self-checking bench for tau_gemm_tile. Expected tiles come |
// |               from a plain-arithmetic matrix product over operand arrays.|
// | Options     : TAU_GEMM_SIGNED_EN selects the signed reference model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tau_gemm_tile;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int WIDTH    = 8;
  localparam int K_MAX    = 16;
  localparam int KW       = $clog2(K_MAX + 1);
  localparam int ACC_BITS = 2 * WIDTH + $clog2(K_MAX);
  localparam int OUT_W    = ROWS * COLS * ACC_BITS;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  i_start;
  logic [KW-1:0]         i_k_len;
  logic                  o_busy;
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic [ROWS*WIDTH-1:0] i_a_col;
  logic [COLS*WIDTH-1:0] i_b_row;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [OUT_W-1:0]      o_out;

  tau_gemm_tile #(
    .ROWS (ROWS), .COLS (COLS), .WIDTH (WIDTH), .K_MAX (K_MAX)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_start     (i_start),
    .i_k_len     (i_k_len),
    .o_busy      (o_busy),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_a_col     (i_a_col),
    .i_b_row     (i_b_row),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out       (o_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] ta  [K_MAX][ROWS];
  logic [WIDTH-1:0] tbo [K_MAX][COLS];

  int hs_count;
  int t_first;
  int t_done;
  int t_start;

  // ---------------- reference model ----------------
  function automatic logic [ACC_BITS-1:0] ref_elem(int i, int j, int n);
    longint s;
    s = 0;
    for (int k = 0; k < n; k++) begin
`ifdef TAU_GEMM_SIGNED_EN
      s += longint'($signed(ta[k][i])) * longint'($signed(tbo[k][j]));
`else
      s += longint'(ta[k][i]) * longint'(tbo[k][j]);
`endif
    end
    return s[ACC_BITS-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] build_exp(int n);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        v[(i*COLS+j)*ACC_BITS +: ACC_BITS] = ref_elem(i, j, n);
    return v;
  endfunction

  task automatic fill_random(int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < ROWS; i++) ta[k][i] = WIDTH'($urandom);
      for (int j = 0; j < COLS; j++) tbo[k][j] = WIDTH'($urandom);
    end
  endtask

  // ---------------- stimulus driver ----------------
  task automatic run_tile(input int klen, input int gap);
    int n;
    int budget;
    n        = (klen > K_MAX) ? K_MAX : klen;
    hs_count = 0;
    t_first  = -1;
    t_done   = -1;
    i_start  = 1'b1;
    i_k_len  = KW'(klen);
    t_start  = cyc;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      repeat (gap) @(negedge clk);
      for (int i = 0; i < ROWS; i++) i_a_col[i*WIDTH +: WIDTH] = ta[k][i];
      for (int j = 0; j < COLS; j++) i_b_row[j*WIDTH +: WIDTH] = tbo[k][j];
      i_in_valid = 1'b1;
      budget = 0;
      while (!o_in_ready && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (!o_in_ready) begin
        checks++; errors++;
        $display("FAIL hs_timeout step %0d in_ready got 0 exp 1", k);
        i_in_valid = 1'b0;
        return;
      end
      if (k == 0) t_first = cyc;
      hs_count++;
      @(negedge clk);
      i_in_valid = 1'b0;
    end
    budget = 0;
    while (!o_out_valid && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (!o_out_valid) begin
      checks++; errors++;
      $display("FAIL done_timeout out_valid got 0 exp 1");
    end
    t_done = cyc;
  endtask

  task automatic finish_out();
    i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) begin
      i_start     = 1'($urandom);
      i_k_len     = KW'($urandom);
      i_in_valid  = 1'($urandom);
      i_out_ready = 1'($urandom);
      i_a_col     = ROWS*WIDTH'($urandom);
      i_b_row     = COLS*WIDTH'($urandom);
      @(negedge clk);
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", o_in_ready); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", o_out_valid); end
    checks++; if (o_out !== '0) begin errors++; $display("FAIL rst_out got %h exp 0", o_out); end
    i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_release busy/out_valid got %b%b exp 00", o_busy, o_out_valid);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < ROWS; i++) ta[0][i] = 8'd3;
    for (int j = 0; j < COLS; j++) tbo[0][j] = 8'd5;
    run_tile(1, 0);
    checks++; if (t_done - t_first != WIDTH + 1) begin
      errors++; $display("FAIL single_latency got %0d exp %0d", t_done - t_first, WIDTH + 1);
    end
    for (int e = 0; e < ROWS*COLS; e++) begin
      checks++;
      if (o_out[e*ACC_BITS +: ACC_BITS] !== ACC_BITS'(15)) begin
        errors++; $display("FAIL single_elem %0d got %0d exp 15", e, o_out[e*ACC_BITS +: ACC_BITS]);
      end
    end
    finish_out();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_idle busy got %b exp 0", o_busy); end
  endtask

  task automatic test_depth();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ROWS; i++) ta[k][i] = WIDTH'(k + 1);
      for (int j = 0; j < COLS; j++) tbo[k][j] = 8'd2;
    end
    run_tile(4, 0);
    checks++; if (t_done - t_first != 4 * (WIDTH + 1)) begin
      errors++; $display("FAIL depth4_latency got %0d exp %0d", t_done - t_first, 4 * (WIDTH + 1));
    end
    for (int e = 0; e < ROWS*COLS; e++) begin
      checks++;
      if (o_out[e*ACC_BITS +: ACC_BITS] !== ACC_BITS'(20)) begin
        errors++; $display("FAIL depth4_elem %0d got %0d exp 20", e, o_out[e*ACC_BITS +: ACC_BITS]);
      end
    end
    finish_out();
    for (int k = 0; k < K_MAX; k++) begin
      for (int i = 0; i < ROWS; i++) ta[k][i] = 8'hFF;
      for (int j = 0; j < COLS; j++) tbo[k][j] = 8'hFF;
    end
    run_tile(16, 0);
    checks++; if (o_out !== build_exp(16)) begin
      errors++; $display("FAIL depth16_max got %h exp %h", o_out, build_exp(16));
    end
`ifndef TAU_GEMM_SIGNED_EN
    checks++; if (o_out[0 +: ACC_BITS] !== ACC_BITS'(1040400)) begin
      errors++; $display("FAIL depth16_elem0 got %0d exp 1040400", o_out[0 +: ACC_BITS]);
    end
`endif
    checks++; if (t_done - t_first != 16 * (WIDTH + 1)) begin
      errors++; $display("FAIL depth16_latency got %0d exp %0d", t_done - t_first, 16 * (WIDTH + 1));
    end
    finish_out();
  endtask

  task automatic test_backpressure();
    int n;
    logic [OUT_W-1:0] exp_v;
    n = int'($urandom_range(2, 6));
    fill_random(n);
    exp_v = build_exp(n);
    run_tile(n, 3);
    checks++; if (hs_count != n) begin errors++; $display("FAIL bp_hs_count got %0d exp %0d", hs_count, n); end
    for (int c = 0; c < 5; c++) begin
      i_start = (c == 1);
      i_k_len = KW'(3);
      checks++; if (o_out_valid !== 1'b1 || o_out !== exp_v) begin
        errors++; $display("FAIL bp_hold cyc %0d valid %b got %h exp %h", c, o_out_valid, o_out, exp_v);
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL bp_still_done got %b exp 1", o_out_valid); end
    finish_out();
    checks++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release busy/valid got %b%b exp 00", o_busy, o_out_valid);
    end
    checks++; if (o_out !== exp_v) begin errors++; $display("FAIL bp_keep got %h exp %h", o_out, exp_v); end
  endtask

  task automatic test_klen_zero();
    run_tile(0, 0);
    checks++; if (t_done - t_start != 1) begin
      errors++; $display("FAIL k0_latency got %0d exp 1", t_done - t_start);
    end
    checks++; if (o_out !== '0) begin errors++; $display("FAIL k0_out got %h exp 0", o_out); end
    finish_out();
  endtask

  task automatic test_klen_over();
    fill_random(K_MAX);
    run_tile(20, 0);
    checks++; if (hs_count != K_MAX) begin errors++; $display("FAIL kover_hs got %0d exp %0d", hs_count, K_MAX); end
    checks++; if (t_done - t_first != K_MAX * (WIDTH + 1)) begin
      errors++; $display("FAIL kover_latency got %0d exp %0d", t_done - t_first, K_MAX * (WIDTH + 1));
    end
    checks++; if (o_out !== build_exp(K_MAX)) begin
      errors++; $display("FAIL kover_out got %h exp %h", o_out, build_exp(K_MAX));
    end
    finish_out();
  endtask

  task automatic test_mid_reset();
    int budget;
    int seen;
    fill_random(3);
    i_start = 1'b1; i_k_len = KW'(3);
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < ROWS; i++) i_a_col[i*WIDTH +: WIDTH] = ta[0][i];
    for (int j = 0; j < COLS; j++) i_b_row[j*WIDTH +: WIDTH] = tbo[0][j];
    i_in_valid = 1'b1;
    budget = 0;
    while (!o_in_ready && budget < 50) begin @(negedge clk); budget++; end
    @(negedge clk);
    i_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b1 || o_in_ready !== 1'b0) begin
      errors++; $display("FAIL mr_in_compute busy/in_ready got %b%b exp 10", o_busy, o_in_ready);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin
      errors++; $display("FAIL mr_async busy/valid/ready got %b%b%b exp 000", o_busy, o_out_valid, o_in_ready);
    end
    checks++; if (o_out !== '0) begin errors++; $display("FAIL mr_out got %h exp 0", o_out); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_out_valid || o_busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mr_aborted active cycles got %0d exp 0", seen); end
  endtask

  task automatic test_sign_case();
    int v;
    logic [ACC_BITS-1:0] e;
    for (int i = 0; i < ROWS; i++) ta[0][i] = 8'd253;
    for (int j = 0; j < COLS; j++) tbo[0][j] = 8'd5;
`ifdef TAU_GEMM_SIGNED_EN
    v = -15;
`else
    v = 1265;
`endif
    e = v[ACC_BITS-1:0];
    run_tile(1, 0);
    for (int el = 0; el < ROWS*COLS; el++) begin
      checks++;
      if (o_out[el*ACC_BITS +: ACC_BITS] !== e) begin
        errors++; $display("FAIL sign_elem %0d got %h exp %h", el, o_out[el*ACC_BITS +: ACC_BITS], e);
      end
    end
    finish_out();
  endtask

  task automatic test_back_to_back();
    int n;
    for (int t = 0; t < 4; t++) begin
      n = int'($urandom_range(1, K_MAX));
      fill_random(n);
      run_tile(n, int'($urandom_range(0, 2)));
      checks++; if (o_out !== build_exp(n)) begin
        errors++; $display("FAIL b2b_tile %0d k %0d got %h exp %h", t, n, o_out, build_exp(n));
      end
      finish_out();
    end
  endtask

  initial begin
    reset_n = 1'b0; i_start = 1'b0; i_k_len = '0; i_in_valid = 1'b0;
    i_out_ready = 1'b0; i_a_col = '0; i_b_row = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_depth();
    test_backpressure();
    test_klen_zero();
    test_klen_over();
    test_mid_reset();
    test_sign_case();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
